// File: rtl/ysyx_23060332_regfile_sb.sv
// ysyx_23060332_regfile_sb: multi-read-port register file with write-pending scoreboard.
// Optional same-cycle writeback forwarding: define YSYX_23060332_REG_BYPASS_EN.
module ysyx_23060332_regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NR_RD  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NR_RD*ADDR_W-1:0] raddr,
    output logic [NR_RD*DATA_W-1:0] rdata,
    output logic [NR_RD-1:0]        rbusy,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_rd,
    output logic                    iss_ready,
    input  logic                    wb_valid,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    output logic [ADDR_W:0]         pend_cnt,
    output logic                    sb_err
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;
    logic              wb_hit;
    logic              wb_same;
    logic              fwd_iss;
    logic              iss_hs;
    logic              inc;
    logic              dec;

    assign wb_hit  = wb_valid && (wb_addr != '0);
    assign wb_same = wb_hit && (wb_addr == iss_rd);

`ifdef YSYX_23060332_REG_BYPASS_EN
    assign fwd_iss = wb_same;
`else
    assign fwd_iss = 1'b0;
`endif

    assign iss_ready = (iss_rd == '0) || !pending[iss_rd] || fwd_iss;
    assign iss_hs    = iss_valid && iss_ready && (iss_rd != '0);

    // Re-reserving a register that retires this cycle leaves the count unchanged.
    assign inc = iss_hs && !pending[iss_rd];
    assign dec = wb_hit && pending[wb_addr] && !(iss_hs && wb_same);

    always_comb begin
        pending_nxt = pending;
        if (wb_hit) pending_nxt[wb_addr] = 1'b0;
        if (iss_hs) pending_nxt[iss_rd] = 1'b1;
    end

    for (genvar k = 0; k < NR_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              b;

        assign a = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            d = '0;
            b = 1'b0;
            if (a != '0) begin
                d = mem[a];
                b = pending[a];
`ifdef YSYX_23060332_REG_BYPASS_EN
                if (wb_valid && (wb_addr == a)) begin
                    d = wb_data;
                    b = 1'b0;
                end
`endif
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = d;
        assign rbusy[k] = b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pending  <= '0;
            pend_cnt <= '0;
            sb_err   <= 1'b0;
        end else begin
            if (wb_hit) begin
                mem[wb_addr] <= wb_data;
                if (!pending[wb_addr]) sb_err <= 1'b1;
            end
            pending  <= pending_nxt;
            pend_cnt <= pend_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
        end
    end
endmodule

// File: tb/tb_ysyx_23060332_regfile_sb.sv
// tb_ysyx_23060332_regfile_sb: directed + randomized check of the scoreboarded regfile
// against an array/bit-vector reference model.
module tb_ysyx_23060332_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int D  = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]  rbusy;
    logic           iss_valid;
    logic [AW-1:0]  iss_rd;
    logic           iss_ready;
    logic           wb_valid;
    logic [AW-1:0]  wb_addr;
    logic [DW-1:0]  wb_data;
    logic [AW:0]    pend_cnt;
    logic           sb_err;

    int ntests = 0;
    int nfail  = 0;

    logic [DW-1:0] mm [D];
    bit            mp [D];
    bit            merr;

    always #5 clk = ~clk;

    ysyx_23060332_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NR_RD(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .pend_cnt(pend_cnt), .sb_err(sb_err)
    );

    function automatic logic [DW-1:0] m_rdata(logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef YSYX_23060332_REG_BYPASS_EN
        if (wb_valid && wb_addr == a) return wb_data;
`endif
        return mm[a];
    endfunction

    function automatic logic m_rbusy(logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef YSYX_23060332_REG_BYPASS_EN
        if (wb_valid && wb_addr == a) return 1'b0;
`endif
        return mp[a];
    endfunction

    function automatic logic m_ready();
        if (iss_rd == 0 || !mp[iss_rd]) return 1'b1;
`ifdef YSYX_23060332_REG_BYPASS_EN
        if (wb_valid && wb_addr == iss_rd) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(mp[i]);
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < D; i++) begin
            mm[i] = '0;
            mp[i] = 1'b0;
        end
        merr = 1'b0;
    endtask

    task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
        ntests++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NR; k++) begin
            chk("rdata", 64'(rdata[k*DW +: DW]), 64'(m_rdata(raddr[k*AW +: AW])));
            chk("rbusy", 64'(rbusy[k]), 64'(m_rbusy(raddr[k*AW +: AW])));
        end
        chk("iss_ready", 64'(iss_ready), 64'(m_ready()));
        chk("pend_cnt", 64'(pend_cnt), 64'(m_cnt()));
        chk("sb_err", 64'(sb_err), 64'(merr));
    endtask

    // Check settled outputs, take one clock edge, advance the model.
    task automatic cycle();
        bit hs;
        #1;
        check_all();
        hs = iss_valid && m_ready();
        @(posedge clk);
        if (rst_n) begin
            if (wb_valid && wb_addr != 0) begin
                if (!mp[wb_addr]) merr = 1'b1;
                mm[wb_addr] = wb_data;
                mp[wb_addr] = 1'b0;
            end
            if (hs && iss_rd != 0) mp[iss_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        wb_valid  = 1'b0;
    endtask

    initial begin
        int cand[$];
        rst_n = 1'b0;
        raddr = '0;
        iss_valid = 1'b0;
        iss_rd = '0;
        wb_valid = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        m_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        for (int a = 0; a < D; a++) begin
            raddr = {AW'(D - 1 - a), AW'(a)};
            #1;
            check_all();
        end

        iss_valid = 1'b1; iss_rd = 5;
        cycle();
        iss_valid = 1'b0; raddr = {5'd0, 5'd5};
        #1;
        chk("rbusy5", 64'(rbusy[0]), 64'd1);
        chk("cnt1", 64'(pend_cnt), 64'd1);
        chk("ready5", 64'(iss_ready), 64'd0);
        wb_valid = 1'b1; wb_addr = 5; wb_data = 32'hDEADBEEF;
        cycle();
        wb_valid = 1'b0;
        #1;
        chk("rd5", 64'(rdata[31:0]), 64'hDEADBEEF);
        chk("rbusy5_clr", 64'(rbusy[0]), 64'd0);
        chk("cnt0", 64'(pend_cnt), 64'd0);
        cycle();

        iss_valid = 1'b1; iss_rd = 7;
        cycle();
        iss_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = 7; wb_data = 32'h1234; raddr = {5'd0, 5'd7};
        #1;
`ifdef YSYX_23060332_REG_BYPASS_EN
        chk("byp_rd7", 64'(rdata[31:0]), 64'h1234);
        chk("byp_busy7", 64'(rbusy[0]), 64'd0);
`else
        chk("nobyp_rd7", 64'(rdata[31:0]), 64'h0);
        chk("nobyp_busy7", 64'(rbusy[0]), 64'd1);
`endif
        cycle();
        wb_valid = 1'b0;
        #1;
        chk("rd7_next", 64'(rdata[31:0]), 64'h1234);
        chk("busy7_next", 64'(rbusy[0]), 64'd0);
        cycle();

        iss_valid = 1'b1; iss_rd = 3;
        cycle();
        wb_valid = 1'b1; wb_addr = 3; wb_data = 32'hABCD; raddr = {5'd0, 5'd3};
        cycle();
        idle();
        #1;
        chk("rd3", 64'(rdata[31:0]), 64'hABCD);
`ifdef YSYX_23060332_REG_BYPASS_EN
        chk("setwins_busy3", 64'(rbusy[0]), 64'd1);
        chk("setwins_cnt", 64'(pend_cnt), 64'd1);
`else
        chk("nobyp_busy3", 64'(rbusy[0]), 64'd0);
        chk("nobyp_cnt", 64'(pend_cnt), 64'd0);
`endif
        cycle();

        iss_valid = 1'b1; iss_rd = 0;
        wb_valid = 1'b1; wb_addr = 0; wb_data = 32'hFFFF; raddr = {5'd0, 5'd0};
        #1;
        chk("ready_r0", 64'(iss_ready), 64'd1);
        chk("rd0", 64'(rdata[31:0]), 64'h0);
        cycle();
        idle();
        #1;
        chk("rd0_after", 64'(rdata[31:0]), 64'h0);
        chk("err_r0", 64'(sb_err), 64'd0);
        cycle();

        wb_valid = 1'b1; wb_addr = 9; wb_data = 32'h99;
        cycle();
        idle(); raddr = {5'd0, 5'd9};
        #1;
        chk("err9", 64'(sb_err), 64'd1);
        chk("rd9", 64'(rdata[31:0]), 64'h99);
        cycle();

        for (int n = 0; n < 400; n++) begin
            cand = {};
            for (int i = 1; i < D; i++) if (mp[i]) cand.push_back(i);
            iss_valid = 1'($urandom);
            iss_rd = AW'($urandom);
            wb_valid = 1'($urandom);
            if (cand.size() > 0 && $urandom_range(3) != 0)
                wb_addr = AW'(cand[$urandom_range(cand.size() - 1)]);
            else
                wb_addr = AW'($urandom);
            wb_data = $urandom;
            raddr = NR*AW'($urandom);
            cycle();
        end
        idle();
        #1;
        chk("err_sticky", 64'(sb_err), 64'd1);

        rst_n = 1'b0;
        m_reset();
        cycle();
        rst_n = 1'b1;
        wb_valid = 1'b1; wb_addr = 9; wb_data = 32'h55;
        cycle();
        wb_valid = 1'b0;
        for (int r = 1; r < D; r++) begin
            iss_valid = 1'b1; iss_rd = AW'(r);
            cycle();
        end
        iss_valid = 1'b0;
        #1;
        chk("cnt31", 64'(pend_cnt), 64'd31);
        chk("err_pre_rst", 64'(sb_err), 64'd1);
        iss_valid = 1'b1; iss_rd = 4; raddr = {5'd9, 5'd5};
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("arst_cnt", 64'(pend_cnt), 64'd0);
        chk("arst_err", 64'(sb_err), 64'd0);
        chk("arst_busy", 64'(rbusy), 64'd0);
        chk("arst_rdata", 64'(rdata), 64'd0);
        chk("arst_ready", 64'(iss_ready), 64'd1);
        iss_rd = 6;
        cycle();
        iss_valid = 1'b0;
        rst_n = 1'b1;
        cycle();
        chk("post_rst_cnt", 64'(pend_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
